// File: rtl/atomic_mem_sequencer_if.sv
// Memory-stage bus bundle: request/response handshake, reservation-set strobes, data BRAM port.
// slave = sequencer side, master = hart/testbench side.
interface atomic_mem_sequencer_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [4:0]            req_tag;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [4:0]            rsp_tag;
   logic [ADDR_WIDTH-1:0] rs_addr;
   logic                  rs_store_op;
   logic                  rs_store_cond_op;
   logic                  rs_load_reserved_op;
   logic                  rs_sc_success;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_re;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_tag,
      input  rs_sc_success, mem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_tag,
      output rs_addr, rs_store_op, rs_store_cond_op, rs_load_reserved_op,
      output mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_tag,
      output rs_sc_success, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_tag,
      input  rs_addr, rs_store_op, rs_store_cond_op, rs_load_reserved_op,
      input  mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/atomic_mem_sequencer.sv
// Sequences LOAD/STORE/LR.W/SC.W onto the data BRAM and reservation set; one op in flight.
// Ports: clk, reset (sync, active-high), bus (slave modport of atomic_mem_sequencer_if).
module atomic_mem_sequencer #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   atomic_mem_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, SC_CHECK, ST_DONE} state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_LR    = 2'b10;
   localparam logic [1:0] OP_SC    = 2'b11;
   localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);
   localparam logic [DATA_WIDTH-1:0] SC_FAIL = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   state_t                state, state_d;
   logic [1:0]            cnt, cnt_d;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [4:0]            tag_q;
   logic                  accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         tag_q   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            tag_q   <= bus.req_tag;
         end
      end
   end

   always_comb begin
      state_d                 = state;
      cnt_d                   = cnt;
      accept                  = 1'b0;
      bus.req_ready           = 1'b0;
      bus.rsp_valid           = 1'b0;
      bus.rsp_data            = '0;
      bus.rsp_tag             = '0;
      bus.rs_addr             = addr_q;
      bus.mem_addr            = addr_q;
      bus.mem_wdata           = wdata_q;
      bus.rs_store_op         = 1'b0;
      bus.rs_store_cond_op    = 1'b0;
      bus.rs_load_reserved_op = 1'b0;
      bus.mem_re              = 1'b0;
      bus.mem_we              = 1'b0;

      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            bus.rs_addr   = bus.req_addr;
            bus.mem_addr  = bus.req_addr;
            bus.mem_wdata = bus.req_wdata;
            accept        = bus.req_valid && !reset;
            if (accept) begin
               unique case (bus.req_op)
                  OP_LOAD: begin
                     bus.mem_re = 1'b1;
                     cnt_d      = CNT_INIT;
                     state_d    = RD_WAIT;
                  end
                  OP_STORE: begin
                     bus.mem_we      = 1'b1;
                     bus.rs_store_op = 1'b1;
                     state_d         = ST_DONE;
                  end
                  OP_LR: begin
                     bus.mem_re              = 1'b1;
                     bus.rs_load_reserved_op = 1'b1;
                     cnt_d                   = CNT_INIT;
                     state_d                 = RD_WAIT;
                  end
                  OP_SC: begin
                     // no memory access yet: the write waits for the verdict
                     bus.rs_store_cond_op = 1'b1;
                     state_d              = SC_CHECK;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         RD_WAIT: begin
            if (cnt == 2'd0) begin
               bus.rsp_valid = 1'b1;
               bus.rsp_data  = bus.mem_rdata;
               bus.rsp_tag   = tag_q;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt - 2'd1;
            end
         end
         SC_CHECK: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_tag   = tag_q;
            if (bus.rs_sc_success && op_q == OP_SC) begin
               bus.mem_we = 1'b1;
            end else begin
               bus.rsp_data = SC_FAIL;
            end
            state_d = IDLE;
         end
         ST_DONE: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_tag   = tag_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // reset aborts in-flight ops combinationally: no late commit or response
      if (reset) begin
         bus.req_ready           = 1'b0;
         bus.rsp_valid           = 1'b0;
         bus.rsp_data            = '0;
         bus.rsp_tag             = '0;
         bus.rs_store_op         = 1'b0;
         bus.rs_store_cond_op    = 1'b0;
         bus.rs_load_reserved_op = 1'b0;
         bus.mem_re              = 1'b0;
         bus.mem_we              = 1'b0;
      end
   end
endmodule
